// File: rtl/hazard_scoreboard_if.sv
// Bundle of D-stage hazard inputs, forwarding-stage state and scoreboard
// results shared between the pipeline and hazard_scoreboard.
//   master : pipeline side, drives sources/stages/md_out, observes results
//   slave  : scoreboard side, consumes pipeline state, drives stall/forwarding
// tst_cnt_load/tst_cnt_val preload stall_cnt for test purposes only.
interface hazard_scoreboard_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FW_STAGES = 2
) ();
  logic [REG_AW-1:0]           rs;
  logic [REG_AW-1:0]           rt;
  logic                        d_read_rs;
  logic                        d_read_rt;
  logic [REG_AW-1:0]           d_rd;
  logic                        d_md_start;
  logic                        flush;
  logic [FW_STAGES-1:0]        st_valid;
  logic [FW_STAGES-1:0]        st_is_load;
  logic [FW_STAGES*REG_AW-1:0] st_rd;
  logic [FW_STAGES*DATA_W-1:0] st_out;
  logic [DATA_W-1:0]           md_out;

  logic                        stall;
  logic                        v1_mux;
  logic                        v2_mux;
  logic [DATA_W-1:0]           v1_fw;
  logic [DATA_W-1:0]           v2_fw;
  logic                        md_busy;
  logic                        md_done;
  logic [REG_AW-1:0]           md_rd;
  logic [31:0]                 stall_cnt;

  logic                        tst_cnt_load;
  logic [31:0]                 tst_cnt_val;

  modport master (
    output rs, rt, d_read_rs, d_read_rt, d_rd, d_md_start, flush,
           st_valid, st_is_load, st_rd, st_out, md_out,
           tst_cnt_load, tst_cnt_val,
    input  stall, v1_mux, v2_mux, v1_fw, v2_fw,
           md_busy, md_done, md_rd, stall_cnt
  );

  modport slave (
    input  rs, rt, d_read_rs, d_read_rt, d_rd, d_md_start, flush,
           st_valid, st_is_load, st_rd, st_out, md_out,
           tst_cnt_load, tst_cnt_val,
    output stall, v1_mux, v2_mux, v1_fw, v2_fw,
           md_busy, md_done, md_rd, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for an in-order pipeline: operand forwarding from the
// E/M stages and a multi-cycle unit, load-use / pending / structural stall
// generation, the multi-cycle unit tracking FSM, and a saturating stall counter.
//   clk    : clock, all state updates on rising edge
//   resetn : asynchronous active-low reset
//   bus    : hazard_scoreboard_if.slave (sources, stage state, results)
module hazard_scoreboard #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FW_STAGES = 2,
  parameter int unsigned MD_LAT    = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  hazard_scoreboard_if.slave   bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] CNT_INIT = 4'(MD_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] md_rd_q, md_rd_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic              md_busy_w;
  logic              md_done_w;
  logic              stall_w;
  logic              accept_w;
  logic              load_use_w;
  logic              pending_w;
  logic              struct_w;
  logic [REG_AW-1:0] rd0_w;

  // Load flags of older stages never cause a load-use stall.
  logic unused_ld;
  assign unused_ld = ^bus.st_is_load;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      md_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_rd_q     <= md_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // FSM outputs
  always_comb begin
    md_busy_w = (state_q == BUSY);
    md_done_w = (state_q == BUSY) && (cnt_q == '0);
  end

  assign bus.md_busy   = md_busy_w;
  assign bus.md_done   = md_done_w;
  assign bus.md_rd     = md_rd_q;
  assign bus.stall_cnt = stall_cnt_q;

  // Hazard detection
  always_comb begin
    rd0_w = bus.st_rd[REG_AW-1:0];

    load_use_w = bus.st_valid[0] && bus.st_is_load[0] && (rd0_w != '0) &&
                 ((bus.d_read_rs && (bus.rs == rd0_w)) ||
                  (bus.d_read_rt && (bus.rt == rd0_w)));

    // md_rd of 0 marks a result nobody consumes, so it never blocks.
    pending_w = md_busy_w && !md_done_w && (md_rd_q != '0) &&
                ((bus.d_read_rs && (bus.rs == md_rd_q)) ||
                 (bus.d_read_rt && (bus.rt == md_rd_q)) ||
                 (bus.d_rd == md_rd_q));

    struct_w = bus.d_md_start && md_busy_w && !md_done_w;

    stall_w  = (load_use_w || pending_w || struct_w) && !bus.flush;
    accept_w = bus.d_md_start && !stall_w && !bus.flush;
  end

  assign bus.stall = stall_w;

  // Forwarding: md result is the fallback, then stages are scanned oldest to
  // youngest so the lowest-index match overwrites and wins.
  always_comb begin
    logic [REG_AW-1:0] rd_i;
    int unsigned       idx;

    bus.v1_mux = 1'b0;
    bus.v1_fw  = '0;
    bus.v2_mux = 1'b0;
    bus.v2_fw  = '0;
    rd_i       = '0;
    idx        = 0;

    if (md_done_w && (md_rd_q != '0)) begin
      if (bus.rs == md_rd_q) begin
        bus.v1_mux = 1'b1;
        bus.v1_fw  = bus.md_out;
      end
      if (bus.rt == md_rd_q) begin
        bus.v2_mux = 1'b1;
        bus.v2_fw  = bus.md_out;
      end
    end

    for (int unsigned k = 0; k < FW_STAGES; k++) begin
      idx  = FW_STAGES - 1 - k;
      rd_i = bus.st_rd[idx*REG_AW +: REG_AW];
      if (bus.st_valid[idx] && (rd_i != '0)) begin
        if (bus.rs == rd_i) begin
          bus.v1_mux = 1'b1;
          bus.v1_fw  = bus.st_out[idx*DATA_W +: DATA_W];
        end
        if (bus.rt == rd_i) begin
          bus.v2_mux = 1'b1;
          bus.v2_fw  = bus.st_out[idx*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_rd_d = md_rd_q;

    case (state_q)
      IDLE: begin
        if (accept_w) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          md_rd_d = bus.d_rd;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          if (accept_w) begin
            // back-to-back issue in the completion cycle
            cnt_d   = CNT_INIT;
            md_rd_d = bus.d_rd;
          end else begin
            state_d = IDLE;
            md_rd_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        md_rd_d = '0;
      end
    endcase
  end

  // Saturating stall counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.tst_cnt_load) begin
      stall_cnt_d = bus.tst_cnt_val;
    end else if (stall_w && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DATA_W, 32, datapath width.
- REG_AW, 5, register index width; register 0 is hardwired zero.
- FW_STAGES, 2, forwarding stages; index 0 is youngest (E), index 1 is next (M).
- MD_LAT, 4, multi-cycle unit latency in cycles; legal range 2..15.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below as name, direction, width, meaning:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- rs, rt  in  REG_AW  D-stage source indices.
- d_read_rs, d_read_rt  in  1  D instruction reads rs / rt.
- d_rd  in  REG_AW  D destination index (0 = none).
- d_md_start  in  1  D instruction issues a multi-cycle op writing d_rd.
- flush  in  1  D instruction is being killed this cycle.
- st_valid, st_is_load  in  FW_STAGES  per-stage valid / load flags.
- st_rd  in  FW_STAGES*REG_AW  packed per-stage destinations; stage i at bits [i*REG_AW +: REG_AW].
- st_out  in  FW_STAGES*DATA_W  packed per-stage results.
- md_out  in  DATA_W  multi-cycle result, valid while md_done=1.
- stall  out  1  hold F/D, inject bubble into E.
- v1_mux, v2_mux  out  1  use forwarded value for rs / rt.
- v1_fw, v2_fw  out  DATA_W  forwarded values.
- md_busy  out  1  multi-cycle op in flight.
- md_done  out  1  completion pulse.
- md_rd  out  REG_AW  destination of in-flight op.
- stall_cnt  out  32  count of stall cycles.

Function
REQ-003 Stage i SHALL match source s when st_valid[i] is 1, st_rd[i] is not 0, and st_rd[i] equals s.
REQ-004 Forwarding for a source SHALL select the lowest-index matching stage; if no stage matches, it SHALL select md_out when md_done is 1, md_rd is not 0 and md_rd equals s; otherwise the mux output is 0 and the fw output is 0.
REQ-005 v1_mux/v1_fw SHALL follow REQ-004 for rs, and v2_mux/v2_fw for rt; the source 0 mux output SHALL always be 0. This is combinational.
REQ-006 Load-use hazard SHALL be: st_valid[0], st_is_load[0], st_rd[0] not 0, and ((d_read_rs and rs equals st_rd[0]) or (d_read_rt and rt equals st_rd[0])).
REQ-007 Pending hazard SHALL be: md_busy, not md_done, md_rd not 0, and (d_read_rs and rs equals md_rd, or d_read_rt and rt equals md_rd, or d_rd equals md_rd); the d_rd term is the WAW case.
REQ-008 Structural hazard SHALL be: d_md_start, md_busy and not md_done.
REQ-009 stall SHALL be the OR of REQ-006 through REQ-008, forced to 0 when flush is 1.
REQ-010 A start SHALL be accepted when d_md_start is 1, stall is 0 and flush is 0.
REQ-011 FSM states SHALL be IDLE and BUSY, with a 4-bit down-counter cnt.
- Accepted start: go to BUSY, cnt is set to MD_LAT-1, md_rd is set to d_rd.
- In BUSY, cnt decrements each cycle.
- md_done is 1 in BUSY when cnt equals 0.
REQ-012 In the md_done cycle:
- An accepted start SHALL reload BUSY with the new cnt and md_rd (back-to-back).
- Otherwise the FSM returns to IDLE and md_rd is cleared to 0.
REQ-013 md_busy SHALL be 1 exactly in BUSY. A start accepted at edge t SHALL give md_done high for the single cycle after edge t+MD_LAT-1.
REQ-014 flush SHALL NOT cancel an in-flight op; it only blocks acceptance in its own cycle.
REQ-015 stall_cnt SHALL increment on each edge where stall is 1, and SHALL saturate at 0xFFFFFFFF.
REQ-016 A start with d_rd equal to 0 SHALL still occupy the unit but SHALL cause no pending or forwarding hazard.

Reset
REQ-017 While resetn is 0, the following SHALL hold immediately, independent of clk:
- FSM in IDLE.
- cnt = 0, md_rd = 0, md_busy = 0, md_done = 0, stall_cnt = 0.
REQ-018 Reset asserted mid-operation SHALL abort the op with no md_done pulse. Combinational outputs SHALL still follow their inputs during reset, with md_* terms inactive.

Verification
REQ-019 Scenario: E valid with rd=5 and out=0xAAAA, M valid with rd=5 and out=0xBBBB; rs=5, d_read_rs=1 -> v1_mux=1, v1_fw=0xAAAA, stall=0.
REQ-020 Scenario: E load with rd=7; D rt=7, d_read_rt=1 -> stall=1 and stall_cnt increments. The same case with d_read_rt=0 -> stall=0.
REQ-021 Scenario: MD_LAT=4, start with d_rd=9 at edge 0; D reads rs=9 on cycles 1-3 -> stall=1. Cycle 4: md_done=1, md_out=0x1234, v1_mux=1, v1_fw=0x1234, stall=0.
REQ-022 Scenario: a second d_md_start while BUSY -> stall=1 until the done cycle; it is accepted in the done cycle and md_busy stays 1 with no gap.
REQ-023 Scenario: start with flush=1 -> md_busy stays 0. A separate test: reset asserted at cnt=2 -> all outputs return to reset values and no md_done pulse appears.
REQ-024 Scenario: force stall=1 for more than 2^32 cycles (preload via a test hook) -> stall_cnt holds at 0xFFFFFFFF; rs=0 with all stages at rd=0 -> v1_mux=0.
